// File: rtl/id_stage_pipe.sv
// Decode stage: register file with write-through, RAW hazard detection and the ID/EXE
// pipeline register with hold, bubble and flush, plus a saturating stall-cycle counter.
module id_stage_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned IMM_W  = 24,
  parameter int unsigned FWD_EN = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] src1_addr_i,
  input  logic [ADDR_W-1:0] src2_addr_i,
  input  logic [ADDR_W-1:0] dest_addr_i,
  input  logic              uses_src1_i,
  input  logic              uses_src2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [3:0]        status_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_dest_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              exe_wb_en_i,
  input  logic              exe_mem_read_i,
  input  logic [ADDR_W-1:0] exe_dest_i,
  input  logic              mem_wb_en_i,
  input  logic [ADDR_W-1:0] mem_dest_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              hazard_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] val1_o,
  output logic [DATA_W-1:0] val2_o,
  output logic [ADDR_W-1:0] src1_o,
  output logic [ADDR_W-1:0] src2_o,
  output logic [ADDR_W-1:0] dest_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [IMM_W-1:0]  imm_o,
  output logic [3:0]        status_o,
  output logic [15:0]       hazard_cnt_o
);

  localparam int unsigned RegN = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf_q [RegN];
  logic [DATA_W-1:0] rd1, rd2;
  logic              raw_exe, raw_mem, hazard;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RegN; i++) rf_q[i] <= '0;
    end else if (wb_en_i) begin
      rf_q[wb_dest_i] <= wb_data_i;
    end
  end

  // Same-cycle writeback bypasses the array so decode never sees a stale value.
  assign rd1 = (wb_en_i && (wb_dest_i == src1_addr_i)) ? wb_data_i : rf_q[src1_addr_i];
  assign rd2 = (wb_en_i && (wb_dest_i == src2_addr_i)) ? wb_data_i : rf_q[src2_addr_i];

  assign raw_exe = (uses_src1_i && (src1_addr_i == exe_dest_i)) ||
                   (uses_src2_i && (src2_addr_i == exe_dest_i));
  assign raw_mem = (uses_src1_i && (src1_addr_i == mem_dest_i)) ||
                   (uses_src2_i && (src2_addr_i == mem_dest_i));

  if (FWD_EN != 0) begin : g_fwd
    assign hazard = in_valid_i && exe_wb_en_i && exe_mem_read_i && raw_exe && !flush_i;
  end else begin : g_nofwd
    assign hazard = in_valid_i && ((exe_wb_en_i && raw_exe) || (mem_wb_en_i && raw_mem)) &&
                    !flush_i;
  end

  assign hazard_o = hazard;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d, val1_q, val1_d, val2_q, val2_d;
  logic [ADDR_W-1:0] src1_q, src1_d, src2_q, src2_d, dest_q, dest_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [3:0]        status_q, status_d;
  logic [15:0]       cnt_q, cnt_d;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    val1_d   = val1_q;
    val2_d   = val2_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    dest_d   = dest_q;
    ctrl_d   = ctrl_q;
    imm_d    = imm_q;
    status_d = status_q;
    cnt_d    = cnt_q;

    // Flush beats stall; a hazard only inserts a bubble when the register is free to move.
    if (flush_i || (!stall_i && hazard)) begin
      valid_d  = 1'b0;
      pc_d     = '0;
      val1_d   = '0;
      val2_d   = '0;
      src1_d   = '0;
      src2_d   = '0;
      dest_d   = '0;
      ctrl_d   = '0;
      imm_d    = '0;
      status_d = '0;
    end else if (!stall_i) begin
      valid_d  = in_valid_i;
      pc_d     = pc_i;
      val1_d   = rd1;
      val2_d   = rd2;
      src1_d   = src1_addr_i;
      src2_d   = src2_addr_i;
      dest_d   = dest_addr_i;
      ctrl_d   = in_valid_i ? ctrl_i : '0;
      imm_d    = imm_i;
      status_d = status_i;
    end

    if (hazard && !stall_i && !flush_i && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      val1_q   <= '0;
      val2_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dest_q   <= '0;
      ctrl_q   <= '0;
      imm_q    <= '0;
      status_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      val1_q   <= val1_d;
      val2_q   <= val2_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      dest_q   <= dest_d;
      ctrl_q   <= ctrl_d;
      imm_q    <= imm_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign pc_o         = pc_q;
  assign val1_o       = val1_q;
  assign val2_o       = val2_q;
  assign src1_o       = src1_q;
  assign src2_o       = src2_q;
  assign dest_o       = dest_q;
  assign ctrl_o       = ctrl_q;
  assign imm_o        = imm_q;
  assign status_o     = status_q;
  assign hazard_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: two instances (FWD_EN=0 and FWD_EN=1) share stimulus.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, uses_src1, uses_src2, wb_en, exe_wb_en, exe_mem_read, mem_wb_en;
  logic        stall, flush;
  logic [31:0] pc, wb_data;
  logic [3:0]  src1, src2, dest, wb_dest, exe_dest, mem_dest, status;
  logic [9:0]  ctrl;
  logic [23:0] imm;

  logic        hazard, out_valid;
  logic [31:0] pc_o, val1, val2;
  logic [3:0]  src1_o, src2_o, dest_o, status_o;
  logic [9:0]  ctrl_o;
  logic [23:0] imm_o;
  logic [15:0] hcnt;

  logic        f_hazard, f_valid;
  logic [31:0] f_pc, f_val1, f_val2;
  logic [3:0]  f_src1, f_src2, f_dest, f_status;
  logic [9:0]  f_ctrl;
  logic [23:0] f_imm;
  logic [15:0] f_hcnt;

  always #5 clk = ~clk;

  id_stage_pipe #(.FWD_EN(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .pc_i(pc),
    .src1_addr_i(src1), .src2_addr_i(src2), .dest_addr_i(dest),
    .uses_src1_i(uses_src1), .uses_src2_i(uses_src2), .ctrl_i(ctrl), .imm_i(imm),
    .status_i(status), .wb_en_i(wb_en), .wb_dest_i(wb_dest), .wb_data_i(wb_data),
    .exe_wb_en_i(exe_wb_en), .exe_mem_read_i(exe_mem_read), .exe_dest_i(exe_dest),
    .mem_wb_en_i(mem_wb_en), .mem_dest_i(mem_dest), .stall_i(stall), .flush_i(flush),
    .hazard_o(hazard), .out_valid_o(out_valid), .pc_o(pc_o), .val1_o(val1), .val2_o(val2),
    .src1_o(src1_o), .src2_o(src2_o), .dest_o(dest_o), .ctrl_o(ctrl_o), .imm_o(imm_o),
    .status_o(status_o), .hazard_cnt_o(hcnt)
  );

  id_stage_pipe #(.FWD_EN(1)) u_fwd (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .pc_i(pc),
    .src1_addr_i(src1), .src2_addr_i(src2), .dest_addr_i(dest),
    .uses_src1_i(uses_src1), .uses_src2_i(uses_src2), .ctrl_i(ctrl), .imm_i(imm),
    .status_i(status), .wb_en_i(wb_en), .wb_dest_i(wb_dest), .wb_data_i(wb_data),
    .exe_wb_en_i(exe_wb_en), .exe_mem_read_i(exe_mem_read), .exe_dest_i(exe_dest),
    .mem_wb_en_i(mem_wb_en), .mem_dest_i(mem_dest), .stall_i(stall), .flush_i(flush),
    .hazard_o(f_hazard), .out_valid_o(f_valid), .pc_o(f_pc), .val1_o(f_val1),
    .val2_o(f_val2), .src1_o(f_src1), .src2_o(f_src2), .dest_o(f_dest), .ctrl_o(f_ctrl),
    .imm_o(f_imm), .status_o(f_status), .hazard_cnt_o(f_hcnt)
  );

  typedef enum int {FHaz, FValid, FPc, FVal1, FVal2, FCtrl, FCnt, FDest, FFHaz, FImm,
                    FStatus, FSrc1, FSrc2} fld_e;
  typedef struct {
    int          cyc;
    fld_e        fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   n_total  = 0;
  int   n_pass   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] field(input fld_e f);
    case (f)
      FHaz:    return {31'd0, hazard};
      FValid:  return {31'd0, out_valid};
      FPc:     return pc_o;
      FVal1:   return val1;
      FVal2:   return val2;
      FCtrl:   return {22'd0, ctrl_o};
      FCnt:    return {16'd0, hcnt};
      FDest:   return {28'd0, dest_o};
      FFHaz:   return {31'd0, f_hazard};
      FImm:    return {8'd0, imm_o};
      FStatus: return {28'd0, status_o};
      FSrc1:   return {28'd0, src1_o};
      default: return {28'd0, src2_o};
    endcase
  endfunction

  // Expectation for the edge that ends the current cycle (inputs stay put until next negedge).
  task automatic ex(input fld_e f, input logic [31:0] v, input string n);
    q.push_back('{edge_cnt + 1, f, v, n});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
        e = q.pop_front();
        check(e.name, field(e.fld), e.val);
      end
    end
  end

  task automatic idle();
    in_valid = 0; pc = 0; src1 = 0; src2 = 0; dest = 0; uses_src1 = 0; uses_src2 = 0;
    ctrl = 0; imm = 0; status = 0; wb_en = 0; wb_dest = 0; wb_data = 0;
    exe_wb_en = 0; exe_mem_read = 0; exe_dest = 0; mem_wb_en = 0; mem_dest = 0;
    stall = 0; flush = 0;
  endtask

  task automatic next();
    @(negedge clk);
    idle();
  endtask

  initial begin : driver
    rst_n = 1'b0;
    idle();
    next(); ex(FValid, 0, "rst_valid"); ex(FCnt, 0, "rst_cnt");
    next(); ex(FPc, 0, "rst_pc");

    // Write-through on R3, first edge after release loads normally.
    next(); rst_n = 1'b1;
    in_valid = 1; pc = 32'h10; wb_en = 1; wb_dest = 3; wb_data = 32'hDEAD_BEEF;
    src1 = 3; uses_src1 = 1; src2 = 4; dest = 5; ctrl = 10'h001; imm = 24'hABCDEF;
    status = 4'hA;
    ex(FValid, 1, "wt_valid"); ex(FPc, 32'h10, "wt_pc"); ex(FVal1, 32'hDEAD_BEEF, "wt_val1");
    ex(FVal2, 0, "wt_val2"); ex(FCtrl, 10'h001, "wt_ctrl"); ex(FImm, 24'hABCDEF, "wt_imm");
    ex(FStatus, 4'hA, "wt_status"); ex(FDest, 5, "wt_dest"); ex(FHaz, 0, "wt_haz");

    next(); in_valid = 1; pc = 32'h14; wb_en = 1; wb_dest = 4; wb_data = 32'h1234_5678;
    src1 = 3; src2 = 4; ctrl = 10'h3FF;
    ex(FVal1, 32'hDEAD_BEEF, "commit_r3"); ex(FVal2, 32'h1234_5678, "wt_r4");
    ex(FCtrl, 10'h3FF, "ctrl_all");

    next(); in_valid = 1; pc = 32'h18; src1 = 4; src2 = 3;
    ex(FVal1, 32'h1234_5678, "read_r4"); ex(FVal2, 32'hDEAD_BEEF, "read_r3");
    ex(FSrc1, 4, "src1_out"); ex(FSrc2, 3, "src2_out");

    // RAW against EXE, non-load then load.
    next(); in_valid = 1; pc = 32'h20; uses_src2 = 1; src2 = 2; exe_wb_en = 1; exe_dest = 2;
    ctrl = 10'h055;
    ex(FHaz, 1, "raw_exe_haz"); ex(FFHaz, 0, "fwd_nonload"); ex(FValid, 0, "bubble_valid");
    ex(FCtrl, 0, "bubble_ctrl"); ex(FPc, 0, "bubble_pc"); ex(FCnt, 1, "cnt_1");

    next(); in_valid = 1; pc = 32'h20; uses_src2 = 1; src2 = 2; exe_wb_en = 1; exe_dest = 2;
    exe_mem_read = 1; ctrl = 10'h055;
    ex(FHaz, 1, "raw_load_haz"); ex(FFHaz, 1, "fwd_loaduse"); ex(FCnt, 2, "cnt_2");

    next(); in_valid = 1; pc = 32'h20; uses_src2 = 1; src2 = 2; ctrl = 10'h055;
    ex(FHaz, 0, "raw_clear"); ex(FValid, 1, "raw_load_valid"); ex(FPc, 32'h20, "raw_load_pc");
    ex(FCtrl, 10'h055, "raw_load_ctrl"); ex(FCnt, 2, "cnt_hold");

    // RAW against MEM; uses_src gating.
    next(); in_valid = 1; pc = 32'h24; uses_src1 = 1; src1 = 7; mem_wb_en = 1; mem_dest = 7;
    ex(FHaz, 1, "raw_mem_haz"); ex(FFHaz, 0, "fwd_mem"); ex(FCnt, 3, "cnt_3");

    next(); in_valid = 1; pc = 32'h24; src1 = 7; mem_wb_en = 1; mem_dest = 7;
    ex(FHaz, 0, "unused_src"); ex(FValid, 1, "mem_load_valid"); ex(FPc, 32'h24, "mem_load_pc");

    // Invalid slot: no hazard, fields captured, control zeroed.
    next(); pc = 32'h28; uses_src2 = 1; src2 = 2; exe_wb_en = 1; exe_dest = 2; ctrl = 10'h055;
    ex(FHaz, 0, "invalid_haz"); ex(FValid, 0, "invalid_valid"); ex(FCtrl, 0, "invalid_ctrl");
    ex(FPc, 32'h28, "invalid_pc");

    next(); in_valid = 1; pc = 32'h40; ctrl = 10'h011;
    ex(FPc, 32'h40, "load_40");

    for (int i = 0; i < 3; i++) begin
      next(); stall = 1; in_valid = 1; pc = 32'h44; ctrl = 10'h022;
      uses_src2 = 1; src2 = 2; exe_wb_en = 1; exe_dest = 2;
      ex(FHaz, 1, "stall_haz"); ex(FPc, 32'h40, "stall_pc"); ex(FValid, 1, "stall_valid");
      ex(FCtrl, 10'h011, "stall_ctrl"); ex(FCnt, 3, "stall_cnt");
    end

    next(); stall = 1; flush = 1; in_valid = 1; pc = 32'h44; ctrl = 10'h022;
    uses_src2 = 1; src2 = 2; exe_wb_en = 1; exe_dest = 2;
    ex(FHaz, 0, "flush_haz"); ex(FFHaz, 0, "flush_fhaz"); ex(FValid, 0, "flush_valid");
    ex(FCtrl, 0, "flush_ctrl"); ex(FPc, 0, "flush_pc"); ex(FCnt, 3, "flush_cnt");

    next(); in_valid = 1; pc = 32'h48; wb_en = 1; wb_dest = 5; wb_data = 32'h0000_CAFE;
    ex(FValid, 1, "pre_rst_valid"); ex(FPc, 32'h48, "pre_rst_pc");

    // Asynchronous reset mid-cycle.
    next(); #2; rst_n = 1'b0; #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_pc", pc_o, 32'd0);
    check("async_cnt", {16'd0, hcnt}, 32'd0);
    next();
    next(); rst_n = 1'b1; in_valid = 1; pc = 32'h4C; src1 = 5; uses_src1 = 1;
    ex(FVal1, 0, "r5_after_rst"); ex(FValid, 1, "post_rst_valid");

    // Saturation of the stall counter.
    for (int i = 1; i <= 65540; i++) begin
      next(); in_valid = 1; uses_src2 = 1; src2 = 2; exe_wb_en = 1; exe_dest = 2;
      if (i == 65534 || i == 65535 || i == 65536 || i == 65540)
        ex(FCnt, (i > 65535) ? 32'hFFFF : i, "sat_cnt");
    end

    next();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode-stage datapath and ID/EXE boundary for the ARM-subset pipeline. It combines a register file with same-cycle write-through, a RAW hazard detector with a selectable forwarding-aware mode, and an ID/EXE pipeline register with hold, bubble and flush. It also keeps a saturating stall-cycle counter. It sits between the IF/ID register and the EXE stage and consumes already-decoded instruction fields.

## Interface
- DATA_W, 32, datapath and PC width
- ADDR_W, 4, register address width; register count REG_N = 2**ADDR_W
- CTRL_W, 10, opaque decoded control bundle (wb_en, mem_r, mem_w, branch, S, exec_cmd[3:0], imm); bit 0 is wb_en, bit 1 is mem_r
- IMM_W, 24, immediate/shift-operand field width
- FWD_EN, 0, 0 = stall on any RAW against EXE/MEM; 1 = stall only on load-use against EXE
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- pc_in  in  DATA_W  instruction PC
- src1_addr, src2_addr, dest_addr  in  ADDR_W  decoded register fields
- uses_src1, uses_src2  in  1  instruction actually reads the source
- ctrl_in  in  CTRL_W  decoded control bundle
- imm_in  in  IMM_W  immediate field
- status_in  in  4  NZCV flags
- wb_en_in, wb_dest, wb_data  in  1/ADDR_W/DATA_W  writeback port
- exe_wb_en, exe_mem_read, exe_dest  in  1/1/ADDR_W  instruction currently in EXE
- mem_wb_en, mem_dest  in  1/ADDR_W  instruction currently in MEM
- stall_in  in  1  downstream freeze: hold ID/EXE register
- flush  in  1  taken branch: kill instruction in ID
- hazard  out  1  combinational; freeze PC and IF/ID
- out_valid  out  1  ID/EXE holds a real instruction
- pc_out, val1, val2  out  DATA_W  registered PC and operand values
- src1_out, src2_out, dest_out  out  ADDR_W  registered addresses (for the forwarding unit)
- ctrl_out  out  CTRL_W  registered control; all-zero on a bubble
- imm_out  out  IMM_W; status_out  out  4
- hazard_cnt  out  16  saturating stall-cycle counter

## Operation
- Register file: REG_N x DATA_W; every entry is 0 at reset. A write occurs on the rising edge when wb_en_in=1. R0 has no special treatment.
- Reads are combinational with write-through: if wb_en_in=1 and wb_dest equals the read address, the read returns wb_data.
- raw1 = uses_src1 and the src1 address matches. raw2 is the same for src2.
- FWD_EN=0: hazard = in_valid & ((exe_wb_en & raw(exe_dest)) | (mem_wb_en & raw(mem_dest))).
- FWD_EN=1: hazard = in_valid & exe_wb_en & exe_mem_read & raw(exe_dest).
- hazard is forced to 0 when flush=1.
- Pipeline register update priority is rst > flush > stall_in > hazard > load:
  - flush: out_valid=0, ctrl_out=0; other fields are don't-care but are cleared to 0.
  - stall_in: every output register holds.
  - hazard: bubble. out_valid=0 and ctrl_out=0; other fields are cleared.
  - load: all fields capture. out_valid=in_valid. ctrl_out=ctrl_in if in_valid, else 0.
- hazard_cnt increments by 1 each cycle with hazard & ~stall_in & ~flush. It saturates at 16'hFFFF.
- Reset, asynchronous on rst=0: every output register is 0, hazard_cnt is 0, and all register-file entries are 0. hazard may be nonzero during reset because it is combinational from inputs.

## Timing
- ID/EXE latency: 1 cycle. Inputs present in cycle N appear on the outputs after edge N.
- Writeback in cycle N is visible to the decode read in cycle N via write-through, and is also committed at edge N.
- hazard is purely combinational, with no registered state.
- A stalled instruction re-evaluates its hazard every cycle. It loads on the first cycle in which hazard=0 and stall_in=0.
- stall_in held for k cycles keeps the outputs constant for k edges.
- flush together with stall_in: flush wins, and the register clears.
- Reset deasserted mid-operation: the first edge after release performs a normal update.

## Test plan
- Reset: assert rst=0 mid-stream. All outputs go to 0 immediately. After release, reading R5 returns 0.
- Write-through: in one cycle, wb_en_in=1, wb_dest=3, wb_data=32'hDEAD_BEEF and src1_addr=3. After the edge, val1=32'hDEADBEEF. A later read of R3 returns the same value.
- FWD_EN=0 RAW: exe_wb_en=1, exe_dest=2, src2_addr=2, uses_src2=1 gives hazard=1. The next edge yields out_valid=0, ctrl_out=0 and hazard_cnt=1. Clearing exe_wb_en loads the instruction.
- FWD_EN=1: the same stimulus with exe_mem_read=0 gives hazard=0. With exe_mem_read=1 it gives hazard=1.
- Priority: flush=1 with stall_in=1 and valid data clears out_valid to 0. stall_in=1 alone holds pc_out=32'h40 for 3 cycles.
- Saturation: preload hazard_cnt near 16'hFFFF, or hold hazard for 65 540 cycles. hazard_cnt stays at 16'hFFFF.
